// File: rtl/spectrum_peak_finder.sv
// spectrum_peak_finder
// Takes one SFFT spectrum frame per rising edge of InputValid and scans the
// lower FREQS bins, one bin per clock. It keeps a sorted top-PEAKS list by
// insertion. When the scan ends it presents the bin indices and the
// saturated amplitudes, together with a one-cycle PeaksValid pulse.
module spectrum_peak_finder #(
    parameter int NFFT             = 8,
    parameter int FREQS            = NFFT / 2,
    parameter int FREQ_WIDTH       = 4,
    parameter int INPUT_AMPL_WIDTH = 32,
    parameter int FINAL_AMPL_WIDTH = 24,
    parameter int PEAKS            = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NFFT-1:0][INPUT_AMPL_WIDTH-1:0]     SFFT_In,
    input  logic                                      InputValid,
    output logic [PEAKS-1:0][FREQ_WIDTH-1:0]          PeakFreqs,
    output logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0]    PeakAmpls,
    output logic                                      PeaksValid,
    output logic                                      Busy,
    output logic                                      FrameDropped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Any amplitude above this value is clipped to all ones on output.
    localparam logic [INPUT_AMPL_WIDTH-1:0] SAT_LIMIT =
        INPUT_AMPL_WIDTH'({FINAL_AMPL_WIDTH{1'b1}});

    state_t state_q, state_d;

    logic                                      inputValid_q;
    logic                                      frameEdge;
    logic                                      lastBin;
    logic                                      frameDropped_q;

    logic [FREQS-1:0][INPUT_AMPL_WIDTH-1:0]    frameBuf_q;
    logic [FREQ_WIDTH-1:0]                     idx_q;
    logic [INPUT_AMPL_WIDTH-1:0]               candAmpl;

    logic [PEAKS-1:0][INPUT_AMPL_WIDTH-1:0]    listAmpl_q, listAmpl_d;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0]          listFreq_q, listFreq_d;
    logic [PEAKS-1:0]                          listValid_q, listValid_d;
    logic [PEAKS-1:0]                          insertHere;
    logic                                      insertSeen;

    logic [PEAKS-1:0][FREQ_WIDTH-1:0]          peakFreqs_q;
    logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0]    peakAmpls_q;

    function automatic logic [FINAL_AMPL_WIDTH-1:0] saturate(
        input logic [INPUT_AMPL_WIDTH-1:0] ampl
    );
        logic [FINAL_AMPL_WIDTH-1:0] result;
        if (ampl > SAT_LIMIT) begin
            result = '1;
        end else begin
            result = ampl[FINAL_AMPL_WIDTH-1:0];
        end
        return result;
    endfunction

    // A frame starts only on a rising InputValid, so a level that is held high
    // yields one capture. The delayed copy is cleared by reset, so a high
    // level just after reset still counts as an edge.
    assign frameEdge = InputValid & ~inputValid_q;
    assign lastBin   = (idx_q == FREQ_WIDTH'(FREQS - 1));

    // Select the current candidate amplitude from the latched frame copy.
    always_comb begin
        candAmpl = '0;
        for (int b = 0; b < FREQS; b++) begin
            if (idx_q == FREQ_WIDTH'(b)) begin
                candAmpl = frameBuf_q[b];
            end
        end
    end

    // Insert the candidate at the first slot that is empty or strictly smaller.
    // Slots below that point shift down by one, and the last slot drops off.
    always_comb begin
        listAmpl_d  = listAmpl_q;
        listFreq_d  = listFreq_q;
        listValid_d = listValid_q;
        insertHere  = '0;
        for (int i = 0; i < PEAKS; i++) begin
            insertHere[i] = ~listValid_q[i] | (listAmpl_q[i] < candAmpl);
        end
        insertSeen = insertHere[0];
        if (insertHere[0]) begin
            listAmpl_d[0]  = candAmpl;
            listFreq_d[0]  = idx_q;
            listValid_d[0] = 1'b1;
        end
        for (int i = 1; i < PEAKS; i++) begin
            if (insertSeen) begin
                listAmpl_d[i]  = listAmpl_q[i-1];
                listFreq_d[i]  = listFreq_q[i-1];
                listValid_d[i] = listValid_q[i-1];
            end else if (insertHere[i]) begin
                listAmpl_d[i]  = candAmpl;
                listFreq_d[i]  = idx_q;
                listValid_d[i] = 1'b1;
            end
            insertSeen = insertSeen | insertHere[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture, then scan each bin, then one presentation cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frameEdge) state_d = SCAN;
            SCAN:    if (lastBin)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. The peak registers are loaded on entry to DONE, so the
    // result is already stable while PeaksValid is high.
    always_comb begin
        Busy       = (state_q != IDLE);
        PeaksValid = (state_q == DONE);
    end

    // Datapath: edge detect, drop flag, frame capture, list update and result load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inputValid_q   <= 1'b0;
            frameDropped_q <= 1'b0;
            frameBuf_q     <= '0;
            idx_q          <= '0;
            listAmpl_q     <= '0;
            listFreq_q     <= '0;
            listValid_q    <= '0;
            peakFreqs_q    <= '0;
            peakAmpls_q    <= '0;
        end else begin
            inputValid_q   <= InputValid;
            frameDropped_q <= frameEdge && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (frameEdge) begin
                        frameBuf_q  <= SFFT_In[FREQS-1:0];
                        idx_q       <= '0;
                        listAmpl_q  <= '0;
                        listFreq_q  <= '0;
                        listValid_q <= '0;
                    end
                end
                SCAN: begin
                    listAmpl_q  <= listAmpl_d;
                    listFreq_q  <= listFreq_d;
                    listValid_q <= listValid_d;
                    if (lastBin) begin
                        peakFreqs_q <= listFreq_d;
                        for (int k = 0; k < PEAKS; k++) begin
                            peakAmpls_q[k] <= saturate(listAmpl_d[k]);
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PeakFreqs    = peakFreqs_q;
    assign PeakAmpls    = peakAmpls_q;
    assign FrameDropped = frameDropped_q;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// tb_spectrum_peak_finder
// This bench applies directed and random frames to spectrum_peak_finder.
// A driver models which frame edges are captured or dropped and queues the
// expected peak sets. A negedge monitor compares every output on every cycle.
module tb_spectrum_peak_finder;

    localparam int NFFT             = 8;
    localparam int FREQS            = 4;
    localparam int FREQ_WIDTH       = 4;
    localparam int INPUT_AMPL_WIDTH = 32;
    localparam int FINAL_AMPL_WIDTH = 24;
    localparam int PEAKS            = 2;

    typedef logic [NFFT-1:0][INPUT_AMPL_WIDTH-1:0]  frame_t;
    typedef logic [PEAKS-1:0][FREQ_WIDTH-1:0]       freqs_t;
    typedef logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] ampls_t;

    typedef struct {
        int     cyc;
        freqs_t freqs;
        ampls_t ampls;
    } expect_t;

    logic   clk;
    logic   reset;
    frame_t SFFT_In;
    logic   InputValid;
    freqs_t PeakFreqs;
    ampls_t PeakAmpls;
    logic   PeaksValid;
    logic   Busy;
    logic   FrameDropped;

    int      cyc = 0;
    int      checksPassed = 0;
    int      checksTotal = 0;
    expect_t expQ[$];
    int      dropQ[$];
    int      lastCapture;
    int      nextFree;
    logic    prevValid;
    freqs_t  lastFreqs;
    ampls_t  lastAmpls;

    spectrum_peak_finder #(
        .NFFT(NFFT), .FREQS(FREQS), .FREQ_WIDTH(FREQ_WIDTH),
        .INPUT_AMPL_WIDTH(INPUT_AMPL_WIDTH), .FINAL_AMPL_WIDTH(FINAL_AMPL_WIDTH),
        .PEAKS(PEAKS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SFFT_In(SFFT_In),
        .InputValid(InputValid),
        .PeakFreqs(PeakFreqs),
        .PeakAmpls(PeakAmpls),
        .PeaksValid(PeaksValid),
        .Busy(Busy),
        .FrameDropped(FrameDropped)
    );

    // Free-running clock and a cycle counter that stamps each clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Compare one value and record the result.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    function automatic frame_t randomFrame();
        frame_t f;
        for (int b = 0; b < NFFT; b++) begin
            case ($urandom_range(0, 3))
                0:       f[b] = $urandom_range(0, 3);
                1:       f[b] = $urandom;
                2:       f[b] = $urandom_range(0, 32'h00FF_FFFF);
                default: f[b] = 32'h00FF_FFFE + $urandom_range(0, 2);
            endcase
        end
        return f;
    endfunction

    function automatic frame_t makeFrame(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
        frame_t f;
        f = randomFrame();
        f[0] = a0;
        f[1] = a1;
        f[2] = a2;
        f[3] = a3;
        return f;
    endfunction

    // Reference model: pick the PEAKS largest of bins 0..FREQS-1 by repeated
    // selection. On equal amplitudes the lower bin wins. Then saturate.
    function automatic void modelPeaks(input frame_t f, output freqs_t freqs,
                                       output ampls_t ampls);
        bit      taken[FREQS];
        int      best;
        longint  amp;
        longint  maxVal;
        maxVal = (longint'(1) << FINAL_AMPL_WIDTH) - 1;
        for (int b = 0; b < FREQS; b++) taken[b] = 1'b0;
        freqs = '0;
        ampls = '0;
        for (int k = 0; k < PEAKS; k++) begin
            best = -1;
            for (int b = 0; b < FREQS; b++) begin
                if (!taken[b] && (best < 0 || f[b] > f[best])) best = b;
            end
            taken[best] = 1'b1;
            amp = longint'(f[best]);
            if (amp > maxVal) amp = maxVal;
            freqs[k] = FREQ_WIDTH'(best);
            ampls[k] = FINAL_AMPL_WIDTH'(amp);
        end
    endfunction

    function automatic void modelReset();
        expQ.delete();
        dropQ.delete();
        lastCapture = -1000;
        nextFree    = 0;
        prevValid   = 1'b0;
        lastFreqs   = '0;
        lastAmpls   = '0;
    endfunction

    // Decide, from the values driven this cycle, whether an edge occurs and
    // whether the DUT takes it or drops it.
    function automatic void evalCycle();
        expect_t e;
        if (InputValid && !prevValid) begin
            if (cyc >= nextFree) begin
                modelPeaks(SFFT_In, e.freqs, e.ampls);
                e.cyc = cyc + FREQS + 1;
                expQ.push_back(e);
                lastCapture = cyc;
                nextFree    = cyc + FREQS + 2;
            end else begin
                dropQ.push_back(cyc + 1);
            end
        end
        prevValid = InputValid;
    endfunction

    // Drive one clock period's inputs just after the rising edge.
    task automatic applyStimulus(input logic valid, input frame_t f);
        @(posedge clk);
        #1;
        InputValid = valid;
        SFFT_In    = f;
        evalCycle();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, randomFrame());
    endtask

    task automatic sendFrame(input frame_t f);
        applyStimulus(1'b1, f);
        idleCycles(FREQS + 2);
    endtask

    // Hold reset for two clocks, check the cleared outputs, then release it.
    task automatic applyReset(input logic validDuring, input frame_t f);
        reset      = 1'b0;
        InputValid = validDuring;
        SFFT_In    = f;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetPeakFreqs", PeakFreqs, '0);
        checkOutput("resetPeakAmpls", PeakAmpls, '0);
        checkOutput("resetPeaksValid", PeaksValid, 1'b0);
        checkOutput("resetBusy", Busy, 1'b0);
        checkOutput("resetFrameDropped", FrameDropped, 1'b0);
        reset = 1'b1;
        evalCycle();
    endtask

    // Monitor: check every output against the model once per cycle.
    always @(negedge clk) begin
        logic    expValid;
        logic    expDrop;
        logic    expBusy;
        expect_t e;
        expValid = (expQ.size() > 0) && (expQ[0].cyc == cyc);
        if (expValid) begin
            e = expQ.pop_front();
            lastFreqs = e.freqs;
            lastAmpls = e.ampls;
        end
        expDrop = (dropQ.size() > 0) && (dropQ[0] == cyc);
        if (expDrop) void'(dropQ.pop_front());
        expBusy = (lastCapture >= 0) && (cyc > lastCapture) &&
                  (cyc <= lastCapture + FREQS + 1);
        checkOutput("PeaksValid", PeaksValid, expValid);
        checkOutput("PeakFreqs", PeakFreqs, lastFreqs);
        checkOutput("PeakAmpls", PeakAmpls, lastAmpls);
        checkOutput("FrameDropped", FrameDropped, expDrop);
        checkOutput("Busy", Busy, expBusy);
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        frame_t f;
        reset      = 1'b0;
        InputValid = 1'b0;
        SFFT_In    = '0;

        // Reset with InputValid high; the frame is captured right after release.
        applyReset(1'b1, randomFrame());
        idleCycles(FREQS + 3);

        // Distinct peaks, ties, all zero, saturation, and a value just below saturation.
        sendFrame(makeFrame(32'd5, 32'd90, 32'd7, 32'd40));
        sendFrame(makeFrame(32'd40, 32'd40, 32'd40, 32'd0));
        sendFrame(makeFrame(32'd0, 32'd0, 32'd0, 32'd0));
        sendFrame(makeFrame(32'h0100_0000, 32'hFFFF_FFFF, 32'd3, 32'd2));
        sendFrame(makeFrame(32'd1, 32'h00FF_FFFE, 32'd9, 32'd2));

        // Re-toggle two cycles after capture: that edge is dropped.
        applyStimulus(1'b1, makeFrame(32'd11, 32'd22, 32'd33, 32'd44));
        applyStimulus(1'b0, randomFrame());
        applyStimulus(1'b1, randomFrame());
        idleCycles(FREQS + 3);

        // An edge in the DONE cycle is dropped as well.
        applyStimulus(1'b1, randomFrame());
        idleCycles(FREQS);
        applyStimulus(1'b1, randomFrame());
        idleCycles(FREQS + 3);

        // InputValid held high for 20 cycles gives exactly one capture.
        repeat (20) applyStimulus(1'b1, randomFrame());
        idleCycles(FREQS + 3);

        // A reset during the scan abandons the frame, and a new frame then works.
        applyStimulus(1'b1, randomFrame());
        applyStimulus(1'b0, randomFrame());
        applyStimulus(1'b0, randomFrame());
        applyReset(1'b0, randomFrame());
        f = randomFrame();
        sendFrame(f);

        // Random frames with random high and low durations.
        repeat (40) begin
            repeat ($urandom_range(1, 3)) applyStimulus(1'b1, randomFrame());
            idleCycles($urandom_range(1, 8));
        end
        idleCycles(FREQS + 4);

        checkOutput("pendingResults", 64'(expQ.size()), 64'd0);
        checkOutput("pendingDrops", 64'(dropQ.size()), 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_finder.md
Name: spectrum_peak_finder

Overview:
- Sits directly downstream of SFFT_Pipeline and consumes one spectrum frame per SFFT OutputValid rising edge.
- Scans the FREQS lower bins one bin per clock and keeps a sorted top-PEAKS list by insertion.
- Presents each peak's bin index and its amplitude, saturated to FINAL_AMPL_WIDTH, to the fingerprint/hash stage with a one-cycle valid pulse.

Parameters:
- NFFT, 8, number of SFFT output bins on the input bus.
- FREQS, NFFT/2, bins scanned (bins 0..FREQS-1); NFFT/2 < FREQS ≤ NFFT is illegal.
- FREQ_WIDTH, 4, bin index width; 2^FREQ_WIDTH ≥ FREQS.
- INPUT_AMPL_WIDTH, 32, unsigned width of each SFFT bin.
- FINAL_AMPL_WIDTH, 24, output amplitude width, with FINAL_AMPL_WIDTH ≤ INPUT_AMPL_WIDTH.
- PEAKS, 2, number of peaks reported, 1 ≤ PEAKS ≤ FREQS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- SFFT_In  in  NFFT x INPUT_AMPL_WIDTH  unsigned bin magnitudes; connects to SFFT_Out.
- InputValid  in  1  connects to SFFT OutputValid; a level signal, edge-detected internally.
- PeakFreqs  out  PEAKS x FREQ_WIDTH  bin indices; entry 0 is the largest.
- PeakAmpls  out  PEAKS x FINAL_AMPL_WIDTH  saturated amplitudes matching PeakFreqs.
- PeaksValid  out  1  one-cycle pulse when a new peak set is presented.
- Busy  out  1  high in SCAN and DONE.
- FrameDropped  out  1  one-cycle pulse when a frame edge arrives while not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All PeakFreqs, PeakAmpls and the working list are cleared to 0.
  - PeaksValid=0, Busy=0, FrameDropped=0.
  - The edge-detect register is cleared to 0, so a high InputValid on the first clock after reset counts as an edge.
  - Reset during SCAN abandons the frame; no PeaksValid is produced.
- Edge detect: frame_edge = InputValid & ~InputValid_q. InputValid_q is registered every cycle.
- IDLE:
  - On frame_edge, latch SFFT_In[0..FREQS-1] into a local frame buffer.
  - Clear the working list: all amplitudes 0, all indices 0, all slot-valid bits 0.
  - Set idx=0 and go to SCAN.
  - The latched copy isolates the scan from later SFFT updates.
- SCAN: one bin per cycle.
  - Candidate is (idx, buf[idx]).
  - Insertion position p is the lowest slot that is either invalid or has amplitude strictly less than the candidate.
  - Slots p..PEAKS-2 shift down one place, the candidate is written at p, and the last slot is discarded.
  - If no such p exists, the list is unchanged.
  - Ties: an equal amplitude never displaces, so the lower bin index ranks higher.
  - Zero-amplitude bins are valid candidates.
  - idx increments each cycle. When idx==FREQS-1 is processed, go to DONE.
- DONE (one cycle):
  - Copy the working list to the output registers.
  - Amplitude saturation: out = (in > 2^FINAL_AMPL_WIDTH-1) ? 2^FINAL_AMPL_WIDTH-1 : in[FINAL_AMPL_WIDTH-1:0].
  - Assert PeaksValid for this one cycle, then return to IDLE.
- Latency: with frame_edge seen at cycle C, PeaksValid is high at cycle C+FREQS+1. Max throughput is one frame per FREQS+2 cycles.
- Outputs hold their last values until the next DONE and are valid whenever PeaksValid has pulsed at least once.
- A frame_edge while in SCAN or DONE:
  - is ignored;
  - pulses FrameDropped the next cycle;
  - does not disturb the scan in progress.
- A frame_edge in the same cycle as the DONE->IDLE transition counts as busy and is dropped. The next edge is needed to capture a frame.
- InputValid held high continuously yields exactly one capture.
- Index arithmetic: idx is FREQ_WIDTH bits and never wraps, because FREQS ≤ 2^FREQ_WIDTH.

Test Plan (NFFT=8, FREQS=4, PEAKS=2, widths 32/24):
- Reset: hold reset=0 for 2 cycles with InputValid=1 -> all outputs 0, Busy=0. Release -> capture on the next posedge, PeaksValid 5 cycles later.
- Distinct peaks: bins [5, 90, 7, 40, x, x, x, x], rise InputValid at cycle C -> PeaksValid at C+5 only; PeakFreqs={1,3}, PeakAmpls={90,40}. Bins 4..7 are ignored.
- Ties and zeros:
  - bins [40, 40, 40, 0] -> PeakFreqs={0,1}, PeakAmpls={40,40}.
  - all-zero frame -> PeakFreqs={0,1}, PeakAmpls={0,0}.
- Saturation:
  - bins [32'h0100_0000, 32'hFFFF_FFFF, 3, 2] -> PeakFreqs={1,0}, PeakAmpls={24'hFFFFFF, 24'hFFFFFF}.
  - bin of 24'hFFFFFE -> passes unchanged.
- Drop and hold:
  - Re-toggle InputValid 2 cycles after capture -> FrameDropped pulses once; first frame's result is unchanged at C+5.
  - InputValid held high for 20 cycles -> exactly one PeaksValid.
- Mid-scan reset: assert reset at C+2 -> no PeaksValid and outputs 0. A new frame after release is processed normally.
